// File: rtl/sim_halt_dump.sv
// Run/halt monitor for the rv32i harness: counts RUN cycles, detects the finish PC,
// then streams a byte range of data memory out as packed beats over valid/ready.
module sim_halt_dump #(
   parameter int                    DATA_WIDTH      = 32,
   parameter logic [DATA_WIDTH-1:0] FINISH_ADDR     = 32'h004c,
   parameter int                    MATCH_CYCLES    = 1,
   parameter int                    ADDR_WIDTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] DUMP_START      = 16'hc000,
   parameter logic [ADDR_WIDTH-1:0] DUMP_END        = 16'hffff,
   parameter int                    BYTES_PER_BEAT  = 8,
   parameter int                    TIMEOUT_CYCLES  = 300000,
   parameter int                    CNT_WIDTH       = 32,
   parameter bit                    DUMP_ON_TIMEOUT = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       pc,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic                        mem_re,
   input  logic [7:0]                  mem_rdata,
   output logic [8*BYTES_PER_BEAT-1:0] dump_data,
   output logic                        dump_valid,
   input  logic                        dump_ready,
   output logic                        dump_last,
   output logic                        halted,
   output logic                        timeout,
   output logic                        done,
   output logic [CNT_WIDTH-1:0]        cycle_count
);

   localparam int                    AW1         = ADDR_WIDTH + 1;
   localparam int                    IDX_W       = $clog2(BYTES_PER_BEAT + 1);
   localparam logic [DATA_WIDTH-1:0] TRIG_PC     = FINISH_ADDR + DATA_WIDTH'(4);
   localparam logic [IDX_W-1:0]      RD_LAST     = IDX_W'(BYTES_PER_BEAT);
   localparam logic [3:0]            MATCH_N     = 4'(MATCH_CYCLES);
   localparam logic [CNT_WIDTH-1:0]  TO_LAST     = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   // One extra bit so a range ending at the top of the address space does not wrap.
   localparam logic [AW1-1:0]        LAST_BASE   = {1'b0, DUMP_END} + AW1'(1) - AW1'(BYTES_PER_BEAT);
   localparam int                    RANGE_BYTES = int'({1'b0, DUMP_END}) - int'({1'b0, DUMP_START}) + 1;

   generate
      if (DUMP_END < DUMP_START || (RANGE_BYTES % BYTES_PER_BEAT) != 0) begin : g_bad_range
         $fatal(1, "sim_halt_dump: dump range must be non-empty and a multiple of BYTES_PER_BEAT");
      end
   endgenerate

   typedef enum logic [1:0] {S_RUN, S_READ, S_OUT, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [3:0]                  match_q;
   logic [IDX_W-1:0]            rd_idx_q;
   logic [AW1-1:0]              base_q;
   logic [8*BYTES_PER_BEAT-1:0] beat_q;
   logic [CNT_WIDTH-1:0]        cyc_q;
   logic                        halted_q, timeout_q;

   logic [3:0]       match_nxt;
   logic             pc_hit, halt_hit, to_hit, last_beat, capture;
   logic [IDX_W-1:0] lane;

   assign match_nxt = match_q + 4'd1;
   assign pc_hit    = (pc == TRIG_PC);
   assign halt_hit  = pc_hit && (match_nxt == MATCH_N);
   assign to_hit    = (cyc_q == TO_LAST) && !halt_hit;
   assign last_beat = (base_q == LAST_BASE);
   // Read k returns during READ step k+1 and lands in lane BYTES_PER_BEAT-1-k.
   assign capture   = (state_q == S_READ) && (rd_idx_q != '0);
   assign lane      = RD_LAST - rd_idx_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RUN;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_d    = state_q;
      mem_re     = 1'b0;
      mem_addr   = '0;
      dump_valid = 1'b0;
      dump_last  = 1'b0;
      case (state_q)
         S_RUN: begin
            if (halt_hit)    state_d = S_READ;
            else if (to_hit) state_d = DUMP_ON_TIMEOUT ? S_READ : S_DONE;
         end
         S_READ: begin
            if (rd_idx_q != RD_LAST) begin
               mem_re   = 1'b1;
               mem_addr = ADDR_WIDTH'(base_q + AW1'(rd_idx_q));
            end else begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            dump_valid = 1'b1;
            dump_last  = last_beat;
            if (dump_ready) state_d = last_beat ? S_DONE : S_READ;
         end
         S_DONE: ;
         default: state_d = S_RUN;
      endcase
   end

   // NOTE: the beat register is reset too, so an aborted dump leaves no stale bytes on dump_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_q   <= '0;
         rd_idx_q  <= '0;
         base_q    <= '0;
         beat_q    <= '0;
         cyc_q     <= '0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               match_q <= pc_hit ? match_nxt : 4'd0;
               if (halt_hit) begin
                  halted_q <= 1'b1;
                  base_q   <= {1'b0, DUMP_START};
                  rd_idx_q <= '0;
               end else if (to_hit) begin
                  timeout_q <= 1'b1;
                  base_q    <= {1'b0, DUMP_START};
                  rd_idx_q  <= '0;
               end else if (cyc_q != '1) begin
                  cyc_q <= cyc_q + 1'b1;
               end
            end
            S_READ: begin
               rd_idx_q <= (rd_idx_q == RD_LAST) ? '0 : rd_idx_q + 1'b1;
               for (int l = 0; l < BYTES_PER_BEAT; l++) begin
                  if (capture && lane == IDX_W'(l)) beat_q[8*l +: 8] <= mem_rdata;
               end
            end
            S_OUT: begin
               if (dump_ready && !last_beat) base_q <= base_q + AW1'(BYTES_PER_BEAT);
            end
            default: ;
         endcase
      end
   end

   assign dump_data   = beat_q;
   assign halted      = halted_q;
   assign timeout     = timeout_q;
   assign done        = (state_q == S_DONE);
   assign cycle_count = cyc_q;

endmodule

// File: tb/tb_sim_halt_dump.sv
// Bench for sim_halt_dump: three configurations share the inputs; a select picks which one
// is observed. Expected beats are assembled straight from the memory image.
module tb_sim_halt_dump;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc = '0;
   logic        dump_ready = 1'b0;
   int          sel = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [7:0]  mem [0:65535];

   logic [15:0] a_addr, b_addr, c_addr;
   logic        a_re, b_re, c_re;
   logic [7:0]  a_rdata = '0, b_rdata = '0, c_rdata = '0;
   logic [63:0] a_data, b_data, c_data;
   logic        a_valid, b_valid, c_valid, a_last, b_last, c_last;
   logic        a_halt, b_halt, c_halt, a_to, b_to, c_to, a_done, b_done, c_done;
   logic [31:0] a_cnt, b_cnt, c_cnt;

   logic [15:0] v_addr;
   logic        v_re, v_valid, v_last, v_halt, v_to, v_done;
   logic [63:0] v_data;
   logic [31:0] v_cnt;

   always #5 clk = ~clk;

   sim_halt_dump #(.DUMP_START(16'h0000), .DUMP_END(16'h000f)) u_a (
      .clk(clk), .rst(rst), .pc(pc), .mem_addr(a_addr), .mem_re(a_re), .mem_rdata(a_rdata),
      .dump_data(a_data), .dump_valid(a_valid), .dump_ready(dump_ready), .dump_last(a_last),
      .halted(a_halt), .timeout(a_to), .done(a_done), .cycle_count(a_cnt));

   sim_halt_dump #(.MATCH_CYCLES(2), .TIMEOUT_CYCLES(100), .DUMP_START(16'h0000), .DUMP_END(16'h000f)) u_b (
      .clk(clk), .rst(rst), .pc(pc), .mem_addr(b_addr), .mem_re(b_re), .mem_rdata(b_rdata),
      .dump_data(b_data), .dump_valid(b_valid), .dump_ready(dump_ready), .dump_last(b_last),
      .halted(b_halt), .timeout(b_to), .done(b_done), .cycle_count(b_cnt));

   sim_halt_dump u_c (
      .clk(clk), .rst(rst), .pc(pc), .mem_addr(c_addr), .mem_re(c_re), .mem_rdata(c_rdata),
      .dump_data(c_data), .dump_valid(c_valid), .dump_ready(dump_ready), .dump_last(c_last),
      .halted(c_halt), .timeout(c_to), .done(c_done), .cycle_count(c_cnt));

   // Synchronous-read memory: data appears one cycle after the strobe.
   always @(posedge clk) begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
      if (c_re) c_rdata <= mem[c_addr];
   end

   always_comb begin
      case (sel)
         1: begin
            v_addr = b_addr; v_re = b_re; v_data = b_data; v_valid = b_valid; v_last = b_last;
            v_halt = b_halt; v_to = b_to; v_done = b_done; v_cnt = b_cnt;
         end
         2: begin
            v_addr = c_addr; v_re = c_re; v_data = c_data; v_valid = c_valid; v_last = c_last;
            v_halt = c_halt; v_to = c_to; v_done = c_done; v_cnt = c_cnt;
         end
         default: begin
            v_addr = a_addr; v_re = a_re; v_data = a_data; v_valid = a_valid; v_last = a_last;
            v_halt = a_halt; v_to = a_to; v_done = a_done; v_cnt = a_cnt;
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] beat_of(input int base);
      logic [63:0] v = '0;
      for (int j = 0; j < 8; j++) v = {v[55:0], mem[base + j]};
      return v;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] p = $urandom & 32'h0000_00fc;
      if (p == 32'h50) p = 32'h54;
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pc = '0; dump_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_cycles(input int n, input bit noise);
      repeat (n) begin
         pc = noise ? rand_pc() : 32'h0;
         @(negedge clk);
      end
   endtask

   // mode 0: always ready; 1: random ready; 2: hold off the first beat for 5 cycles.
   task automatic run_dump(input string tag, input int start, input int nbeats, input int mode, input int budget);
      int beat = 0, cyc = 0, n_re = 0, stall_left = 5;
      int bad_stable = 0, bad_re = 0, bad_addr = 0;
      bit was_stalled = 1'b0, r;
      logic [63:0] held = '0;
      while (beat < nbeats && cyc < budget) begin
         if (mode == 1)                                   r = ($urandom_range(0, 3) != 0);
         else if (mode == 2 && v_valid && beat == 0 && stall_left > 0) begin
            r = 1'b0; stall_left--;
         end else                                         r = 1'b1;
         dump_ready = r;
         if (v_re && v_valid) bad_re++;
         if (v_re) begin
            if (int'(v_addr) != start + n_re) bad_addr++;
            n_re++;
         end
         if (was_stalled && (!v_valid || v_data !== held)) bad_stable++;
         was_stalled = 1'b0;
         if (v_valid) begin
            if (r) begin
               check({tag, " data"}, v_data, beat_of(start + 8 * beat));
               check({tag, " last"}, v_last, beat == nbeats - 1);
               beat++;
            end else begin
               was_stalled = 1'b1;
               held = v_data;
            end
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, " beats"}, beat, nbeats);
      check({tag, " reads"}, n_re, 8 * nbeats);
      check({tag, " read order"}, bad_addr, 0);
      check({tag, " no read in out"}, bad_re, 0);
      check({tag, " stall stable"}, bad_stable, 0);
      if (mode == 2) check({tag, " stall used"}, stall_left, 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " mem_addr"}, v_addr, 0);
      check({tag, " mem_re"}, v_re, 0);
      check({tag, " dump_data"}, v_data, 0);
      check({tag, " dump_valid"}, v_valid, 0);
      check({tag, " dump_last"}, v_last, 0);
      check({tag, " halted"}, v_halt, 0);
      check({tag, " timeout"}, v_to, 0);
      check({tag, " done"}, v_done, 0);
      check({tag, " cycle_count"}, v_cnt, 0);
   endtask

   // Halt at cycle t on the selected instance: pc idles for t cycles, then hits the trigger.
   task automatic halt_at(input string tag, input int t, input bit noise, input int start);
      run_cycles(t, noise);
      check({tag, " pre-halt"}, v_halt, 0);
      pc = 32'h50;
      @(negedge clk);
      check({tag, " halted"}, v_halt, 1);
      check({tag, " halt count"}, v_cnt, t);
      check({tag, " first read"}, {v_re, v_addr}, {1'b1, 16'(start)});
      pc = rand_pc();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, viol;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);

      // Reset state
      #1 rst = 1'b1;
      @(negedge clk); @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #0 check_zero($sformatf("reset%0d", s));
      end
      sel = 0;
      @(negedge clk);
      rst = 1'b0;

      // Halt at cycle 20, two beats, sink always ready
      halt_at("basic", 20, 1'b0, 0);
      run_dump("basic", 0, 2, 0, 200);
      check("basic done", v_done, 1);
      check("basic count", v_cnt, 20);
      check("basic timeout", v_to, 0);
      pc = 32'h50;
      run_cycles(5, 1'b1);
      check("basic terminal", {v_done, v_halt, v_re, v_valid}, 4'b1100);
      check("basic frozen", v_cnt, 20);

      // Backpressure on the first beat
      do_reset();
      halt_at("bp", 20, 1'b0, 0);
      run_dump("bp", 0, 2, 2, 200);
      check("bp done", v_done, 1);

      // Reset asserted mid-READ of beat 1
      do_reset();
      halt_at("rmid", 20, 1'b0, 0);
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("rmid async");
      @(negedge clk);
      pc = '0;
      @(negedge clk);
      rst = 1'b0;
      run_cycles(7, 1'b0);
      check("rmid restart count", v_cnt, 7);
      pc = 32'h50;
      @(negedge clk);
      check("rmid rehalt", v_halt, 1);
      check("rmid start addr", {v_re, v_addr}, {1'b1, 16'h0000});
      run_dump("rmid", 0, 2, 1, 400);

      // Randomized halt times, memory contents and sink readiness
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
         do_reset();
         t = $urandom_range(1, 40);
         halt_at($sformatf("rnd%0d", it), t, 1'b1, 0);
         run_dump($sformatf("rnd%0d", it), 0, 2, 1, 400);
         check($sformatf("rnd%0d done", it), v_done, 1);
         check($sformatf("rnd%0d count", it), v_cnt, t);
      end

      // MATCH_CYCLES=2: a single-cycle glitch must not halt
      sel = 1;
      do_reset();
      run_cycles(5, 1'b0);
      pc = 32'h50; @(negedge clk);
      check("glitch single", v_halt, 0);
      pc = 32'h10; @(negedge clk);
      pc = 32'h50; @(negedge clk);
      check("glitch first of two", v_halt, 0);
      @(negedge clk);
      check("glitch halted", v_halt, 1);
      check("glitch count", v_cnt, 8);
      run_dump("glitch", 0, 2, 1, 400);
      check("glitch done", v_done, 1);

      // Halt lands on the timeout cycle: halt wins
      do_reset();
      run_cycles(98, 1'b0);
      pc = 32'h50; @(negedge clk);
      check("tie pre", {v_halt, v_to}, 2'b00);
      @(negedge clk);
      check("tie flags", {v_halt, v_to}, 2'b10);
      check("tie count", v_cnt, 99);
      run_dump("tie", 0, 2, 1, 400);
      check("tie done", v_done, 1);

      // Timeout without dump
      do_reset();
      run_cycles(99, 1'b1);
      check("to pre", {v_to, v_done}, 2'b00);
      check("to pre count", v_cnt, 99);
      @(negedge clk);
      check("to flags", {v_to, v_done, v_halt}, 3'b110);
      check("to count", v_cnt, 99);
      viol = 0;
      pc = 32'h50;
      dump_ready = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (v_valid || v_re) viol++;
      end
      check("to no beats", viol, 0);
      check("to terminal", {v_to, v_done, v_halt}, 3'b110);
      check("to frozen", v_cnt, 99);

      // Full default range up to the top of the address space
      sel = 2;
      do_reset();
      t = $urandom_range(1, 30);
      halt_at("full", t, 1'b1, 16'hc000);
      run_dump("full", 16'hc000, 2048, 1, 40000);
      check("full done", v_done, 1);
      check("full count", v_cnt, t);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sim_halt_dump.md
Name: sim_halt_dump

Overview:
- Parametrised run/halt monitor and memory dump sequencer for the rv32i core harness.
- Counts cycles after reset and watches the fetch PC for a programmable finish address.
- On finish, or optionally on timeout, reads a byte range of data memory through a spare read port and streams it out as packed beats over a valid/ready handshake.
- The dump can go to a bench writer, UART or trace FIFO, so on-chip runs get the same end-of-test dump as simulation.

Parameters:
- DATA_WIDTH, 32, width of the monitored PC.
- FINISH_ADDR, 32'h004c, address of the final instruction. Trigger PC is FINISH_ADDR+4.
- MATCH_CYCLES, 1, consecutive cycles the trigger PC must be seen before halt (1..15).
- ADDR_WIDTH, 16, byte address width of the dump read port.
- DUMP_START, 16'hc000, first byte address dumped.
- DUMP_END, 16'hffff, last byte address dumped (inclusive).
- BYTES_PER_BEAT, 8, bytes packed per output beat (1..8).
- TIMEOUT_CYCLES, 300000, cycle limit for the RUN state.
- CNT_WIDTH, 32, cycle counter width.
- DUMP_ON_TIMEOUT, 0, when 1 a timeout also performs the dump.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: asynchronous, active-high.
- pc, in, DATA_WIDTH, core fetch PC (ft_pc).
- mem_addr, out, ADDR_WIDTH, dump read byte address.
- mem_re, out, 1, read strobe.
- mem_rdata, in, 8, read data, valid exactly 1 cycle after mem_re.
- dump_data, out, 8*BYTES_PER_BEAT, packed beat. Lowest address is in the MSB byte.
- dump_valid, out, 1, beat valid.
- dump_ready, in, 1, sink accepts the beat.
- dump_last, out, 1, final beat of the range.
- halted, out, 1, finish detected (sticky).
- timeout, out, 1, cycle limit reached (sticky).
- done, out, 1, sequence complete (sticky).
- cycle_count, out, CNT_WIDTH, cycles spent in RUN.

Behaviour:
- Reset (async assert, sync release): state=RUN. All outputs are 0: mem_addr, mem_re, dump_data, dump_valid, dump_last, halted, timeout, done, cycle_count. The match counter is 0. Reset asserted mid-dump aborts immediately; no partial beat remains visible.
- Elaboration check: (DUMP_END-DUMP_START+1) must be a multiple of BYTES_PER_BEAT, and DUMP_END must be >= DUMP_START. Otherwise the check reports a fatal error.
- RUN:
  - cycle_count increments every cycle and saturates at all-ones.
  - Match counter: increments while pc==FINISH_ADDR+4 and clears on any other pc.
  - When the match counter reaches MATCH_CYCLES: halted=1 in the next cycle, then go to READ with the beat base set to DUMP_START.
  - If cycle_count==TIMEOUT_CYCLES-1 and no halt this cycle: timeout=1. Go to READ if DUMP_ON_TIMEOUT, else DONE.
  - If halt and timeout occur in the same cycle, halt wins and timeout stays 0.
- READ:
  - Issue BYTES_PER_BEAT back-to-back reads: mem_re=1, mem_addr=base+k for k=0..BYTES_PER_BEAT-1, one per cycle.
  - Each byte is captured one cycle after its read, into byte lane (BYTES_PER_BEAT-1-k).
  - After the last capture (BYTES_PER_BEAT+1 cycles after READ entry) go to OUT. mem_re=0 outside READ.
- OUT:
  - dump_valid=1. dump_data and dump_last are held stable until dump_valid&&dump_ready.
  - dump_last=1 iff base==DUMP_END+1-BYTES_PER_BEAT. This compare uses ADDR_WIDTH+1 bits so DUMP_END=all-ones never wraps.
  - On handshake with dump_last=0: base+=BYTES_PER_BEAT, go to READ. dump_valid drops for the READ period.
  - On handshake with dump_last=1: go to DONE.
- DONE: done=1 and terminal until reset. pc is ignored. cycle_count is frozen, and also frozen in READ/OUT.
- dump_ready is ignored outside OUT. pc changes after halt have no effect.

Test Plan:
- Halt and dump, params DUMP_START=0, DUMP_END=15, BYTES_PER_BEAT=8, dump_ready tied 1: memory preloaded with bytes 0x00..0x0F, pc steps to 0x50 at cycle 20. Required: halted=1 at cycle 21; beat1=0x0001020304050607 with dump_last=0; beat2=0x08090A0B0C0D0E0F with dump_last=1; then done=1 and cycle_count=20.
- Backpressure: same stimulus, dump_ready low for 5 cycles during beat1. Required: dump_valid stays 1, data stable, no mem_re pulses; beat2 follows correctly.
- MATCH_CYCLES=2 glitch: pc=0x50 for 1 cycle, then 0x10, then 0x50 for 2 cycles. Required: no halt after the single cycle; halted=1 after the 2-cycle run.
- Timeout: TIMEOUT_CYCLES=100, DUMP_ON_TIMEOUT=0, pc never matches. Required: timeout=1, done=1, halted=0, no beats, cycle_count=99.
- Full range and wrap: DUMP_START=16'hc000, DUMP_END=16'hffff, BYTES_PER_BEAT=8. Required: exactly 2048 beats; last beat base=0xfff8 with dump_last=1; mem_addr never wraps to 0x0000.
- Reset mid-dump: assert rst during beat 1 READ. Required: all outputs 0 asynchronously; after release RUN restarts with cycle_count=0, and the next halt dumps from DUMP_START.
